// File: rtl/arg_max_frame.sv
// arg_max_frame: streaming |x|^2 arg-max over frames of complex I/Q samples.
//
// Each accepted sample passes through a three-stage pipeline:
//   S1 squares I and Q, S2 sums and saturates the magnitude, S3 tracks the running
//   maximum and loads the frame result when the frame-end sample arrives.
// A frame ends on the sample at position len_eff-1 or on any sample with s_axis_tlast.
// The effective length is latched from frame_len on the first sample of each frame.
// The whole pipeline stalls while a result is pending and not accepted downstream.
//
// Optional feature macro: ARG_MAX_THRESH_EN adds threshold / peak_flag.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_axis_tvalid   input sample valid
//   s_axis_tready   input sample accepted when tvalid & tready
//   xi, xq          signed I / Q samples
//   s_axis_tlast    ends the current frame on this sample
//   frame_len       frame length (0 or > MAX_LENGTH means MAX_LENGTH)
//   m_axis_tvalid   frame result valid
//   m_axis_tready   downstream accepts the result
//   out_max         saturated peak |x|^2 of the frame
//   index           0-based position of the peak (earliest on ties)
//   count           number of samples in the frame
//   peak_flag       out_max > threshold (ARG_MAX_THRESH_EN only)
//   threshold       detection threshold (ARG_MAX_THRESH_EN only)

module arg_max_frame #(
  parameter int unsigned MAX_LENGTH   = 16,
  parameter int unsigned INDEX_BITS   = 4,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned OUT_MAX_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic signed [DATA_BITS-1:0] xi,
  input  logic signed [DATA_BITS-1:0] xq,
  input  logic                        s_axis_tlast,
  input  logic [INDEX_BITS:0]         frame_len,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [OUT_MAX_BITS-1:0]     out_max,
  output logic [INDEX_BITS-1:0]       index,
  output logic [INDEX_BITS:0]         count
`ifdef ARG_MAX_THRESH_EN
  ,
  output logic                        peak_flag,
  input  logic [OUT_MAX_BITS-1:0]     threshold
`endif
);

  localparam int unsigned SUM_W  = 2 * DATA_BITS;
  localparam int unsigned WIDE_W = (SUM_W > OUT_MAX_BITS) ? SUM_W : OUT_MAX_BITS;
  localparam logic [INDEX_BITS:0] MAX_LEN = (INDEX_BITS + 1)'(MAX_LENGTH);
  localparam logic [WIDE_W-1:0]   MAG_CAP = WIDE_W'({OUT_MAX_BITS{1'b1}});

  // Input-side frame tracking
  logic [INDEX_BITS-1:0]   r_pos;
  logic [INDEX_BITS:0]     r_len;

  // S1 registers
  logic                    r_s1_valid;
  logic [SUM_W-1:0]        r_isq;
  logic [SUM_W-1:0]        r_qsq;
  logic [INDEX_BITS-1:0]   r_s1_pos;
  logic                    r_s1_last;

  // S2 registers
  logic                    r_s2_valid;
  logic [OUT_MAX_BITS-1:0] r_mag;
  logic [INDEX_BITS-1:0]   r_s2_pos;
  logic                    r_s2_last;

  // S3 running maximum
  logic [OUT_MAX_BITS-1:0] r_max;
  logic [INDEX_BITS-1:0]   r_max_idx;

  logic                    w_advance;
  logic                    w_accept;
  logic [INDEX_BITS:0]     w_len_eff;
  logic [INDEX_BITS:0]     w_len_cur;
  logic                    w_frame_end;
  logic signed [SUM_W-1:0] w_xi_ext;
  logic signed [SUM_W-1:0] w_xq_ext;
  logic signed [SUM_W-1:0] w_isq;
  logic signed [SUM_W-1:0] w_qsq;
  logic [SUM_W-1:0]        w_sum;
  logic [WIDE_W-1:0]       w_sum_wide;
  logic [OUT_MAX_BITS-1:0] w_mag;
  logic                    w_first;
  logic                    w_take;
  logic [OUT_MAX_BITS-1:0] w_new_max;
  logic [INDEX_BITS-1:0]   w_new_idx;
  logic                    w_load;

  // Any pending result that is not being consumed freezes every stage.
  assign w_advance     = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !rst && w_advance;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  assign w_len_eff   = (frame_len == '0 || frame_len > MAX_LEN) ? MAX_LEN : frame_len;
  // On the first sample the live frame_len applies; afterwards the latched value.
  assign w_len_cur   = (r_pos == '0) ? w_len_eff : r_len;
  assign w_frame_end = s_axis_tlast || ({1'b0, r_pos} == w_len_cur - (INDEX_BITS + 1)'(1));

  // Squares of DATA_BITS-wide signed values always fit in SUM_W bits.
  assign w_xi_ext = {{DATA_BITS{xi[DATA_BITS-1]}}, xi};
  assign w_xq_ext = {{DATA_BITS{xq[DATA_BITS-1]}}, xq};
  assign w_isq    = w_xi_ext * w_xi_ext;
  assign w_qsq    = w_xq_ext * w_xq_ext;

  assign w_sum      = r_isq + r_qsq;
  assign w_sum_wide = WIDE_W'(w_sum);
  assign w_mag      = (w_sum_wide > MAG_CAP) ? {OUT_MAX_BITS{1'b1}}
                                             : w_sum_wide[OUT_MAX_BITS-1:0];

  // Strict compare keeps the earliest index on ties.
  assign w_first   = (r_s2_pos == '0);
  assign w_take    = w_first || (r_mag > r_max);
  assign w_new_max = w_take ? r_mag : r_max;
  assign w_new_idx = w_take ? r_s2_pos : r_max_idx;
  assign w_load    = r_s2_valid && r_s2_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos         <= '0;
      r_len         <= '0;
      r_s1_valid    <= 1'b0;
      r_isq         <= '0;
      r_qsq         <= '0;
      r_s1_pos      <= '0;
      r_s1_last     <= 1'b0;
      r_s2_valid    <= 1'b0;
      r_mag         <= '0;
      r_s2_pos      <= '0;
      r_s2_last     <= 1'b0;
      r_max         <= '0;
      r_max_idx     <= '0;
      m_axis_tvalid <= 1'b0;
      out_max       <= '0;
      index         <= '0;
      count         <= '0;
    end else begin
      if (w_accept) begin
        if (r_pos == '0) begin
          r_len <= w_len_eff;
        end
        r_pos <= w_frame_end ? '0 : r_pos + INDEX_BITS'(1);
      end

      if (w_advance) begin
        r_s1_valid <= w_accept;
        r_isq      <= w_isq;
        r_qsq      <= w_qsq;
        r_s1_pos   <= r_pos;
        r_s1_last  <= w_frame_end;

        r_s2_valid <= r_s1_valid;
        r_mag      <= w_mag;
        r_s2_pos   <= r_s1_pos;
        r_s2_last  <= r_s1_last;

        if (r_s2_valid) begin
          r_max     <= w_new_max;
          r_max_idx <= w_new_idx;
        end

        // Advancing means any held result is consumed now, so valid follows the load.
        m_axis_tvalid <= w_load;
        if (w_load) begin
          out_max <= w_new_max;
          index   <= w_new_idx;
          count   <= {1'b0, r_s2_pos} + (INDEX_BITS + 1)'(1);
        end
      end
    end
  end

`ifdef ARG_MAX_THRESH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_flag <= 1'b0;
    end else if (w_advance && w_load) begin
      peak_flag <= (w_new_max > threshold);
    end
  end
`endif

endmodule

// File: tb/tb_arg_max_frame.sv
`timescale 1ns/1ps
module tb_arg_max_frame;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic signed [11:0] xi;
  logic signed [11:0] xq;
  logic        s_axis_tlast;
  logic [4:0]  frame_len;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] out_max;
  logic [3:0]  index;
  logic [4:0]  count;
`ifdef ARG_MAX_THRESH_EN
  logic        peak_flag;
  logic [15:0] threshold;
`endif

  typedef struct {
    int mx;
    int idx;
    int cnt;
  } res_t;

  res_t exp_q[$];
  int   m_pos, m_len, m_max, m_idx;
  int   n_tests, n_fail;
  bit   drv_done;

  arg_max_frame #(
    .MAX_LENGTH   (16),
    .INDEX_BITS   (4),
    .DATA_BITS    (12),
    .OUT_MAX_BITS (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .xi            (xi),
    .xq            (xq),
    .s_axis_tlast  (s_axis_tlast),
    .frame_len     (frame_len),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .out_max       (out_max),
    .index         (index),
    .count         (count)
`ifdef ARG_MAX_THRESH_EN
    ,
    .peak_flag     (peak_flag),
    .threshold     (threshold)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  // Reference model: walks accepted samples one by one, applying the frame rules.
  function automatic int mag_of(int i, int q);
    int m;
    m = i * i + q * q;
    return (m > 65535) ? 65535 : m;
  endfunction

  function automatic void model_accept(int i, int q, int fl, bit last);
    int mg;
    mg = mag_of(i, q);
    if (m_pos == 0) begin
      m_len = (fl == 0 || fl > 16) ? 16 : fl;
      m_max = mg;
      m_idx = 0;
    end else if (mg > m_max) begin
      m_max = mg;
      m_idx = m_pos;
    end
    if (last || m_pos == m_len - 1) begin
      exp_q.push_back('{m_max, m_idx, m_pos + 1});
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endfunction

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input int i, input int q, input int fl, input bit last);
    bit done;
    done = 1'b0;
    xi = 12'(i);
    xq = 12'(q);
    frame_len = 5'(fl);
    s_axis_tlast = last;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 500 && !done; k++) begin
      #1;
      if (s_axis_tready) begin
        @(posedge clk);
        model_accept(i, q, fl, last);
        done = 1'b1;
      end
      @(negedge clk);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: tready=%0b want 1 within 500 cycles", s_axis_tready);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (m_axis_tvalid) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    xi = '0;
    xq = '0;
    frame_len = '0;
    m_axis_tready = 1'b1;
`ifdef ARG_MAX_THRESH_EN
    threshold = '0;
`endif
    repeat (3) @(negedge clk);
    n_tests++;
    if ({m_axis_tvalid, out_max, index, count} !== 26'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b max=%0d idx=%0d cnt=%0d want all 0",
               m_axis_tvalid, out_max, index, count);
    end
    n_tests++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tready: got %0b want 0", s_axis_tready);
    end
`ifdef ARG_MAX_THRESH_EN
    n_tests++;
    if (peak_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_peak_flag: got %0b want 0", peak_flag);
    end
`endif
    rst = 1'b0;
    #1;
    n_tests++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL tready_after_reset: got %0b want 1", s_axis_tready);
    end
    @(negedge clk);
    m_pos = 0;
    exp_q.delete();
  endtask

  task automatic test_basic();
    send(1, 0, 4, 0);
    send(3, 4, 4, 0);
    send(0, 2, 4, 0);
    send(5, 0, 4, 0);
    @(negedge clk);
    n_tests++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_latency_early: valid got %0b want 0 at T+2", m_axis_tvalid);
    end
    @(negedge clk);
    n_tests++;
    if ({m_axis_tvalid, out_max, index, count} !== {1'b1, 16'd25, 4'd1, 5'd4}) begin
      n_fail++;
      $display("FAIL basic_result: got v=%0b max=%0d idx=%0d cnt=%0d want 1 25 1 4",
               m_axis_tvalid, out_max, index, count);
    end
    @(negedge clk);
    n_tests++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consumed: valid got %0b want 0", m_axis_tvalid);
    end
  endtask

  task automatic test_ties();
    bit ok;
    send(3, 4, 3, 0);
    send(4, 3, 3, 0);
    send(5, 0, 3, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd25, 4'd0, 5'd3}) begin
      n_fail++;
      $display("FAIL ties: got v=%0b max=%0d idx=%0d cnt=%0d want 1 25 0 3",
               ok, out_max, index, count);
    end
    @(negedge clk);
  endtask

  task automatic test_tlast();
    bit ok;
    send(1, 0, 8, 0);
    send(3, 0, 8, 0);
    send(2, 0, 8, 1);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd9, 4'd1, 5'd3}) begin
      n_fail++;
      $display("FAIL tlast: got v=%0b max=%0d idx=%0d cnt=%0d want 1 9 1 3",
               ok, out_max, index, count);
    end
    @(negedge clk);
    // Next frame must restart at position 0; length 1 makes it a single-sample frame.
    send(5, 5, 1, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd50, 4'd0, 5'd1}) begin
      n_fail++;
      $display("FAIL len_one: got v=%0b max=%0d idx=%0d cnt=%0d want 1 50 0 1",
               ok, out_max, index, count);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    bit ok;
    send(10, 0, 2, 0);
    send(-2048, -2048, 2, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd65535, 4'd1, 5'd2}) begin
      n_fail++;
      $display("FAIL saturation: got v=%0b max=%0d idx=%0d cnt=%0d want 1 65535 1 2",
               ok, out_max, index, count);
    end
    @(negedge clk);
    // frame_len=0 clamps to 16; magnitudes k^2 peak on the last sample.
    for (int k = 0; k < 16; k++) send(k, 0, 0, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd225, 4'd15, 5'd16}) begin
      n_fail++;
      $display("FAIL len_clamp: got v=%0b max=%0d idx=%0d cnt=%0d want 1 225 15 16",
               ok, out_max, index, count);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit ok;
    m_axis_tready = 1'b0;
    send(2, 0, 2, 0);
    send(0, 6, 2, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd36, 4'd1, 5'd2}) begin
      n_fail++;
      $display("FAIL bp_result: got v=%0b max=%0d idx=%0d cnt=%0d want 1 36 1 2",
               ok, out_max, index, count);
    end
    xi = 12'sd1;
    xq = 12'sd1;
    frame_len = 5'd2;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_tests++;
      if ({s_axis_tready, m_axis_tvalid, out_max, index, count} !==
          {1'b0, 1'b1, 16'd36, 4'd1, 5'd2}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b max=%0d idx=%0d cnt=%0d want 0 1 36 1 2",
                 k, s_axis_tready, m_axis_tvalid, out_max, index, count);
      end
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    send(1, 1, 2, 0);
    n_tests++;
    if (m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid got %0b want 0", m_axis_tvalid);
    end
    send(3, 3, 2, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd18, 4'd1, 5'd2}) begin
      n_fail++;
      $display("FAIL bp_next: got v=%0b max=%0d idx=%0d cnt=%0d want 1 18 1 2",
               ok, out_max, index, count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit seen;
    send(9, 0, 4, 0);
    xi = 12'sd1;
    xq = 12'sd0;
    s_axis_tvalid = 1'b1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (s_axis_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_tready: got %0b want 0", s_axis_tready);
    end
    @(negedge clk);
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    m_pos = 0;
    exp_q.delete();
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seen |= m_axis_tvalid;
      @(negedge clk);
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_discard: partial frame result seen=%0b want 0", seen);
    end
`ifdef ARG_MAX_THRESH_EN
    threshold = 16'd48;
`endif
    send(7, 0, 2, 0);
    send(1, 1, 2, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || {out_max, index, count} !== {16'd49, 4'd0, 5'd2}) begin
      n_fail++;
      $display("FAIL rst_newframe: got v=%0b max=%0d idx=%0d cnt=%0d want 1 49 0 2",
               ok, out_max, index, count);
    end
`ifdef ARG_MAX_THRESH_EN
    n_tests++;
    if (peak_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL peak_flag_48: got %0b want 1", peak_flag);
    end
    @(negedge clk);
    threshold = 16'd49;
    send(7, 0, 2, 0);
    send(1, 1, 2, 0);
    wait_valid(10, ok);
    n_tests++;
    if (!ok || peak_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL peak_flag_49: got v=%0b flag=%0b want 1 0", ok, peak_flag);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_random();
    bit   held_v;
    logic [24:0] held;
    int   budget;
    res_t e;
    m_pos = 0;
    exp_q.delete();
    drv_done = 1'b0;
    held_v = 1'b0;
    held = '0;
    budget = 0;
    fork
      begin
        int i, q, fl;
        bit last;
        for (int n = 0; n < 400; n++) begin
          if ($urandom_range(0, 1) == 0) begin
            i = $urandom_range(0, 6) - 3;
            q = $urandom_range(0, 6) - 3;
          end else begin
            i = $urandom_range(0, 4095) - 2048;
            q = $urandom_range(0, 4095) - 2048;
          end
          fl = $urandom_range(0, 20);
          last = ($urandom_range(0, 7) == 0);
          send(i, q, fl, last);
          if ($urandom_range(0, 5) == 0) @(negedge clk);
        end
        send(0, 0, 1, 1);
        drv_done = 1'b1;
      end
      begin
        while (!drv_done || (exp_q.size() > 0 && budget < 200)) begin
          @(negedge clk);
          if (drv_done) budget++;
          m_axis_tready = ($urandom_range(0, 3) != 0);
          if (held_v) begin
            n_tests++;
            if ({m_axis_tvalid, out_max, index, count} !== {1'b1, held}) begin
              n_fail++;
              $display("FAIL rand_stall_hold: got v=%0b max=%0d idx=%0d cnt=%0d want held %0h",
                       m_axis_tvalid, out_max, index, count, held);
            end
          end
          if (m_axis_tvalid && m_axis_tready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
              n_fail++;
              $display("FAIL rand_extra: got max=%0d idx=%0d cnt=%0d want no result",
                       out_max, index, count);
            end else begin
              e = exp_q.pop_front();
              if ({out_max, index, count} !== {16'(e.mx), 4'(e.idx), 5'(e.cnt)}) begin
                n_fail++;
                $display("FAIL rand_result: got max=%0d idx=%0d cnt=%0d want %0d %0d %0d",
                         out_max, index, count, e.mx, e.idx, e.cnt);
              end
            end
          end
          held_v = m_axis_tvalid && !m_axis_tready;
          held = {out_max, index, count};
        end
      end
    join
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_missing: %0d results outstanding want 0", exp_q.size());
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_ties();
    test_tlast();
    test_saturation();
    test_backpressure();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
